// File: rtl/bool_sweep_eval.sv
// Sequential truth-table evaluator: latches an N_IN-input function on start and
// streams every input vector with its output over a valid/ready interface.
module bool_sweep_eval #(
  parameter int N_IN = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [(1<<N_IN)-1:0]  func_tt,
  input  logic                  gray_mode,
  output logic [N_IN-1:0]       out_vec,
  output logic                  out_s,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [N_IN:0]         ones_cnt
);

  localparam int TT_W = 1 << N_IN;
  localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(TT_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [N_IN:0]     idx_q;
  logic [TT_W-1:0]   tt_q;
  logic              mode_q;
  logic [N_IN:0]     ones_q;
  logic [N_IN-1:0]   bin_vec;
  logic              fire;
  logic              last_beat;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready && last_beat) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake is qualified by state, not by out_valid, so out_ready never
  // reaches an output combinationally.
  assign fire      = (state_q == RUN) && out_ready;
  assign last_beat = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      tt_q   <= '0;
      mode_q <= 1'b0;
      ones_q <= '0;
    end else if (state_q == IDLE && start) begin
      idx_q  <= '0;
      tt_q   <= func_tt;
      mode_q <= gray_mode;
      ones_q <= '0;
    end else if (fire) begin
      ones_q <= ones_q + (N_IN+1)'(out_s);
      // Index holds at the last vector; it never wraps within a sweep.
      if (!last_beat) idx_q <= idx_q + (N_IN+1)'(1);
    end
  end

  assign bin_vec  = idx_q[N_IN-1:0];
  assign out_vec  = mode_q ? (bin_vec ^ (bin_vec >> 1)) : bin_vec;
  assign out_s    = tt_q[out_vec];
  assign ones_cnt = ones_q;

endmodule

// File: tb/tb_bool_sweep_eval.sv
// Scoreboard bench for bool_sweep_eval: a 3-input and a 4-input instance,
// expected beats queued at start and compared as the sink accepts them.
module tb_bool_sweep_eval;

  typedef struct {
    logic [7:0] vec;
    logic       s;
  } beat_t;

  localparam int BUDGET = 200;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start3, gray3, ready3;
  logic [7:0] func3;
  logic [2:0] vec3;
  logic       s3, valid3, busy3, done3;
  logic [3:0] ones3;

  logic        start4, gray4, ready4;
  logic [15:0] func4;
  logic [3:0]  vec4;
  logic        s4, valid4, busy4, done4;
  logic [4:0]  ones4;

  bool_sweep_eval #(.N_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .func_tt(func3),
    .gray_mode(gray3), .out_vec(vec3), .out_s(s3), .out_valid(valid3),
    .out_ready(ready3), .busy(busy3), .done(done3), .ones_cnt(ones3)
  );

  bool_sweep_eval #(.N_IN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .func_tt(func4),
    .gray_mode(gray4), .out_vec(vec4), .out_s(s4), .out_valid(valid4),
    .out_ready(ready4), .busy(busy4), .done(done4), .ones_cnt(ones4)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t q3[$];
  beat_t q4[$];
  int    mon_ones3, mon_ones4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sink-side monitors: compare each accepted beat against the queue head and
  // check the running count reflects only previously accepted beats.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy3) check("cnt3_run", ones3, mon_ones3);
      if (valid3 && ready3) begin
        if (q3.size() == 0) check("q3_extra_beat", q3.size(), 1);
        else begin
          beat_t e;
          e = q3.pop_front();
          check("vec3", vec3, e.vec);
          check("s3", s3, e.s);
          mon_ones3 = mon_ones3 + int'(e.s);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy4) check("cnt4_run", ones4, mon_ones4);
      if (valid4 && ready4) begin
        if (q4.size() == 0) check("q4_extra_beat", q4.size(), 1);
        else begin
          beat_t e;
          e = q4.pop_front();
          check("vec4", vec4, e.vec);
          check("s4", s4, e.s);
          mon_ones4 = mon_ones4 + int'(e.s);
        end
      end
    end
  end

  task automatic push_sweep3(input logic [7:0] tt, input logic gray);
    q3.delete();
    mon_ones3 = 0;
    for (int i = 0; i < 8; i++) begin
      beat_t  b;
      logic [2:0] v;
      v     = 3'(i);
      if (gray) v = v ^ (v >> 1);
      b.vec = {5'd0, v};
      b.s   = tt[v];
      q3.push_back(b);
    end
  endtask

  // Full sweep on the 3-input instance. stall_at >= 0 holds ready low for
  // three cycles while that beat is presented; restart pulses start mid-run.
  task automatic sweep3(input logic [7:0] tt, input logic gray, input int stall_at,
                        input bit restart, input int exp_done_cycle);
    int cyc, beats, stall_left;
    push_sweep3(tt, gray);
    func3  = tt;
    gray3  = gray;
    ready3 = 1'b1;
    start3 = 1'b1;
    tick();
    start3     = 1'b0;
    cyc        = 1;
    beats      = 0;
    stall_left = 3;
    while (cyc < BUDGET) begin
      if (done3) break;
      if (stall_at >= 0 && beats == stall_at && stall_left > 0) begin
        ready3 = 1'b0;
        stall_left--;
        check("stall_vec", vec3, 32'(stall_at));
        check("stall_s", s3, tt[stall_at]);
      end else begin
        ready3 = 1'b1;
      end
      if (restart && cyc == 3) begin
        start3 = 1'b1;
        func3  = 8'h00;
      end else begin
        start3 = 1'b0;
      end
      if (valid3 && ready3) beats++;
      tick();
      cyc++;
    end
    check("sweep3_in_budget", cyc < BUDGET, 1);
    if (exp_done_cycle > 0) check("done3_cycle", cyc, exp_done_cycle);
    check("done3_busy_low", busy3, 0);
    check("ones3_final", ones3, $countones(tt));
    check("q3_drained", q3.size(), 0);
    start3 = 1'b0;
    ready3 = 1'b1;
    tick();
    check("done3_once", done3, 0);
    tick();
    tick();
    check("idle3_busy", busy3, 0);
    check("ones3_hold", ones3, $countones(tt));
  endtask

  task automatic sweep4();
    int cyc;
    q4.delete();
    mon_ones4 = 0;
    for (int i = 0; i < 16; i++) begin
      beat_t b;
      logic [3:0] v;
      v     = 4'(i);
      b.vec = {4'd0, v};
      b.s   = ^v;
      q4.push_back(b);
    end
    func4  = 16'h6996;
    gray4  = 1'b0;
    ready4 = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    cyc    = 1;
    while (cyc < 4 * BUDGET) begin
      if (done4) break;
      ready4 = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    check("sweep4_in_budget", cyc < 4 * BUDGET, 1);
    check("ones4_final", ones4, 8);
    check("q4_drained", q4.size(), 0);
    ready4 = 1'b1;
    tick();
    check("done4_once", done4, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start3 = 1'b0; func3 = '0; gray3 = 1'b0; ready3 = 1'b1;
    start4 = 1'b0; func4 = '0; gray4 = 1'b0; ready4 = 1'b1;
    mon_ones3 = 0;
    mon_ones4 = 0;
    tick();
    tick();
    check("rst_valid3", valid3, 0);
    check("rst_busy3", busy3, 0);
    check("rst_done3", done3, 0);
    check("rst_ones3", ones3, 0);
    check("rst_vec3", vec3, 0);
    check("rst_valid4", valid4, 0);
    rst_n = 1'b1;
    tick();

    sweep3(8'hCD, 1'b0, -1, 1'b0, 9);  // binary order
    sweep3(8'hCD, 1'b1, -1, 1'b0, 9);  // Gray order
    sweep3(8'hCD, 1'b0, 2, 1'b0, 0);   // backpressure on beat 2
    sweep3(8'hCD, 1'b0, -1, 1'b1, 9);  // start during RUN ignored

    // Abort after four accepted beats; outputs must drop without a clock edge.
    push_sweep3(8'hCD, 1'b0);
    func3  = 8'hCD;
    gray3  = 1'b0;
    ready3 = 1'b1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("pre_abort_vec3", vec3, 4);
    #1 rst_n = 1'b0;
    #1;
    check("abort_valid3", valid3, 0);
    check("abort_busy3", busy3, 0);
    check("abort_done3", done3, 0);
    check("abort_ones3", ones3, 0);
    q3.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("post_abort_done3", done3, 0);
    sweep3(8'hCD, 1'b0, -1, 1'b0, 9);

    sweep4();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
